// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, FSM state type and index-to-one-hot helper for rr_arbiter8
package arb_pkg;
  localparam int N = 8;
  localparam int IDXW = 3;
  typedef enum logic {IDLE, GRANT} state_e;
  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] i);
    return N'(1) << i;
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: arbiter bus (en/req/done in; gnt/gnt_idx/gnt_valid/timeout out); master drives requests, slave is the arbiter
interface rr_arbiter8_if;
  import arb_pkg::*;
  logic en;
  logic done;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic gnt_valid;
  logic timeout;
  modport master (output en, req, done, input gnt, gnt_idx, gnt_valid, timeout);
  modport slave (input en, req, done, output gnt, gnt_idx, gnt_valid, timeout);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder (req, ptr in; idx = first set req bit at or after ptr mod N, any = |req)
module rr_pick
  import arb_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = N - 1; i >= 0; i--) idx = req[ptr + IDXW'(i)] ? ptr + IDXW'(i) : idx;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin grant holder with release on done/req drop/en drop/hold limit (clk, rst, bus slave)
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  localparam int CW = MAX_HOLD < 1 ? 1 : $clog2(MAX_HOLD + 1);
  state_e state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [N-1:0] gnt_q, gnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic valid_q, valid_d, to_q, to_d, pick_any, lim, rel, go, drop;
  rr_pick u_pick (.req(bus.req), .ptr(ptr_q), .idx(pick_idx), .any(pick_any));
  // hold_q counts completed grant cycles, so reaching MAX_HOLD-1 means this is the last allowed one
  assign lim  = (MAX_HOLD != 0) && (hold_q == CW'(MAX_HOLD - 1));
  assign rel  = bus.done | ~bus.req[idx_q] | ~bus.en | lim;
  assign go   = (state_q == IDLE) && bus.en && pick_any;
  assign drop = (state_q == GRANT) && rel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      valid_q <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      to_q    <= to_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (go ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  always_comb begin
    idx_d   = go ? pick_idx : drop ? '0 : idx_q;
    gnt_d   = go ? onehot(pick_idx) : drop ? '0 : gnt_q;
    valid_d = go | (valid_q & ~drop);
    ptr_d   = drop ? idx_q + 1'b1 : ptr_q;
    hold_d  = (state_q == GRANT) ? ((hold_q == CW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1) : '0;
    // a coincident done, req drop or en drop makes the release a normal one
    to_d    = drop & lim & ~bus.done & bus.req[idx_q] & bus.en;
  end
  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: table vectors, hand sequences and randomized model check of rr_arbiter8
module tb_rr_arbiter8;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rst;
  rr_arbiter8_if bus();
  rr_arbiter8 #(.MAX_HOLD(MH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic r, e;
    logic [7:0] q;
    logic d;
    logic [7:0] g;
    logic [2:0] i;
    logic v, t;
  } vec_t;
  vec_t tbl[$];
  int checks = 0, errors = 0;
  int owner, mptr, held;
  bit mto;
  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic d);
    @(negedge clk);
    rst = r; bus.en = e; bus.req = q; bus.done = d;
    @(posedge clk);
    if (r) begin
      owner = -1; mptr = 0; held = 0; mto = 0;
    end else if (owner < 0) begin
      mto = 0;
      if (e && q != 0)
        for (int k = 7; k >= 0; k--) if (q[(mptr + k) % 8]) owner = (mptr + k) % 8;
      held = (owner >= 0) ? 1 : 0;
    end else if (d || !q[owner] || !e || held == MH) begin
      mto = (held == MH) && !d && q[owner] && e;
      mptr = (owner + 1) % 8;
      owner = -1;
      held = 0;
    end else begin
      held++;
      mto = 0;
    end
    #1;
  endtask
  task automatic check(input string name, input logic [7:0] g, input logic [2:0] i, input logic v, input logic t);
    checks++;
    if (bus.gnt !== g || bus.gnt_idx !== i || bus.gnt_valid !== v || bus.timeout !== t) begin
      errors++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b timeout=%b, want gnt=%h idx=%0d valid=%b timeout=%b",
               name, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, g, i, v, t);
    end
  endtask
  task automatic check_model(input string name);
    logic [7:0] g;
    g = (owner >= 0) ? 8'(1 << owner) : 8'h00;
    check(name, g, (owner >= 0) ? 3'(owner) : 3'd0, owner >= 0, mto);
  endtask
  function automatic vec_t mk(input logic r, e, input logic [7:0] q, input logic d,
                              input logic [7:0] g, input logic [2:0] i, input logic v, t);
    vec_t x;
    x.r = r; x.e = e; x.q = q; x.d = d; x.g = g; x.i = i; x.v = v; x.t = t;
    return x;
  endfunction
  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.req = '0; bus.done = 1'b0;
    owner = -1; mptr = 0; held = 0; mto = 0;
    tbl.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h10, 0, 8'h10, 4, 1, 0));
    tbl.push_back(mk(0, 1, 8'h10, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h50, 0, 8'h40, 6, 1, 0));
    tbl.push_back(mk(0, 1, 8'h50, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h00, 0, 0, 1));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'h01, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h08, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 1, 8'h08, 0, 8'h08, 3, 1, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h10, 4, 1, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'hFF, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h20, 5, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h20, 5, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h20, 5, 1, 0));
    tbl.push_back(mk(1, 1, 8'hFF, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 0, 8'h01, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hFF, 1, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 1, 8'h00, 0, 0, 0));
    foreach (tbl[n]) begin
      step(tbl[n].r, tbl[n].e, tbl[n].q, tbl[n].d);
      check($sformatf("vec%0d", n), tbl[n].g, tbl[n].i, tbl[n].v, tbl[n].t);
    end
    step(1, 1, 8'hFF, 0);
    check("rot_reset", 8'h00, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      step(0, 1, 8'hFF, 0);
      check($sformatf("rot_grant%0d", k), 8'(1 << (k % 8)), 3'(k % 8), 1, 0);
      step(0, 1, 8'hFF, 1);
      check($sformatf("rot_gap%0d", k), 8'h00, 0, 0, 0);
    end
    step(1, 0, 8'h00, 0);
    check_model("rand_reset");
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 8'($urandom),
           $urandom_range(0, 5) == 0);
      check_model($sformatf("rand%0d", k));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
